// File: rtl/tlb_update_arbiter.sv
// Round-robin arbiter for the TLB update stream with a built-in flush sequencer.
// Optional per-source/flush statistics counters are enabled by defining TLB_ARB_STATS_EN.
module tlb_update_arbiter #(
  parameter int N_SRC     = 2,
  parameter int TLB_BITS  = 128,
  parameter int TLB_ORDER = 10
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [N_SRC-1:0]          s_tvalid,
  output logic [N_SRC-1:0]          s_tready,
  input  logic [N_SRC*TLB_BITS-1:0] s_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [TLB_BITS-1:0]       m_tdata,
  output logic                      m_tlast,
  input  logic                      flush_req,
  output logic                      flush_busy,
  output logic                      flush_done
`ifdef TLB_ARB_STATS_EN
  ,
  input  logic                      stat_clr,
  output logic [N_SRC*32-1:0]       stat_grants,
  output logic [31:0]               stat_flushes
`endif
);

  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int IDX_W = TLB_ORDER + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((1 << TLB_ORDER) - 1);
  localparam logic [PTR_W-1:0] LAST_SRC = PTR_W'(N_SRC - 1);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               state_r;
  logic [PTR_W-1:0]     rr_r;
  logic [IDX_W-1:0]     idx_r;
  logic                 pending_r;
  logic                 m_tvalid_r;
  logic [TLB_BITS-1:0]  m_tdata_r;
  logic                 busy_r;
  logic                 done_r;

  logic                 free_s;
  logic                 gnt_found_s;
  logic [PTR_W-1:0]     gnt_idx_s;
  logic [PTR_W-1:0]     cand_s;
  logic                 take_s;
  logic                 xfer_s;
  logic [PTR_W-1:0]     rr_next_s;
  logic [TLB_BITS-1:0]  gnt_data_s;

  // Invalidate beat: flush flag in the MSB, set index in the low bits.
  function automatic logic [TLB_BITS-1:0] inval_beat(input logic [IDX_W-1:0] idx);
    logic [TLB_BITS-1:0] beat;
    beat                = '0;
    beat[TLB_BITS-1]    = 1'b1;
    beat[TLB_ORDER-1:0] = idx[TLB_ORDER-1:0];
    return beat;
  endfunction

  assign free_s     = !m_tvalid_r || m_tready;
  assign m_tvalid   = m_tvalid_r;
  assign m_tdata    = m_tdata_r;
  assign m_tlast    = 1'b0;
  assign flush_busy = busy_r;
  assign flush_done = done_r;
  assign xfer_s     = |s_tready;
  assign gnt_data_s = s_tdata[int'(gnt_idx_s)*TLB_BITS +: TLB_BITS];
  assign rr_next_s  = (gnt_idx_s == LAST_SRC) ? PTR_W'(0) : gnt_idx_s + PTR_W'(1);

  // Round-robin search: first valid source at or after the pointer.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    cand_s      = '0;
    take_s      = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      cand_s      = PTR_W'((int'(rr_r) + k) % N_SRC);
      take_s      = !gnt_found_s && s_tvalid[cand_s];
      gnt_idx_s   = take_s ? cand_s : gnt_idx_s;
      gnt_found_s = gnt_found_s || take_s;
    end
  end

  // Ready only to the winner, only in ARB with no flush waiting, only when the output can load.
  always_comb begin
    s_tready = '0;
    if (aresetn && (state_r == ST_ARB) && !pending_r && free_s && gnt_found_s) begin
      s_tready[gnt_idx_s] = 1'b1;
    end else begin
      s_tready = '0;
    end
  end

  // Arbitration / flush FSM and output register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r    <= ST_ARB;
      rr_r       <= '0;
      idx_r      <= '0;
      pending_r  <= 1'b0;
      m_tvalid_r <= 1'b0;
      m_tdata_r  <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (flush_req && !busy_r && !pending_r) begin
        pending_r <= 1'b1;
      end
      case (state_r)
        ST_ARB: begin
          if (free_s) begin
            if (pending_r) begin
              state_r    <= ST_FLUSH;
              busy_r     <= 1'b1;
              pending_r  <= 1'b0;
              idx_r      <= '0;
              m_tvalid_r <= 1'b0;
            end else if (xfer_s) begin
              m_tvalid_r <= 1'b1;
              m_tdata_r  <= gnt_data_s;
              rr_r       <= rr_next_s;
            end else begin
              m_tvalid_r <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          if (free_s) begin
            m_tvalid_r <= 1'b1;
            m_tdata_r  <= inval_beat(idx_r);
            idx_r      <= idx_r + IDX_W'(1);
            if (idx_r == LAST_IDX) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (m_tvalid_r && m_tready) begin
            m_tvalid_r <= 1'b0;
            done_r     <= 1'b1;
            busy_r     <= 1'b0;
            state_r    <= ST_ARB;
          end
        end
        default: begin
          state_r    <= ST_ARB;
          m_tvalid_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

`ifdef TLB_ARB_STATS_EN
  logic [31:0] grant_cnt_r [N_SRC];
  logic [31:0] flush_cnt_r;

  // Saturating per-source accepted-beat counters; clear wins over increment.
  always_ff @(posedge aclk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (!aresetn || stat_clr) begin
        grant_cnt_r[i] <= 32'd0;
      end else if (s_tvalid[i] && s_tready[i] && (grant_cnt_r[i] != 32'hFFFF_FFFF)) begin
        grant_cnt_r[i] <= grant_cnt_r[i] + 32'd1;
      end
    end
  end

  // Wrapping count of completed flushes.
  always_ff @(posedge aclk) begin
    if (!aresetn || stat_clr) begin
      flush_cnt_r <= 32'd0;
    end else if (done_r) begin
      flush_cnt_r <= flush_cnt_r + 32'd1;
    end
  end

  for (genvar g = 0; g < N_SRC; g++) begin : g_stat
    assign stat_grants[g*32 +: 32] = grant_cnt_r[g];
  end
  assign stat_flushes = flush_cnt_r;
`endif

endmodule

// File: tb/tb_tlb_update_arbiter.sv
// Scoreboard bench for tlb_update_arbiter (N_SRC=2, TLB_ORDER=2): directed stimulus,
// expected beats queued by the stimulus and checked by an independent monitor.
module tb_tlb_update_arbiter;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [1:0]    s_tvalid = 2'b00;
  logic [1:0]    s_tready;
  logic [255:0]  s_tdata = '0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [127:0]  m_tdata;
  logic          m_tlast;
  logic          flush_req = 1'b0;
  logic          flush_busy;
  logic          flush_done;

  logic [127:0]  exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            done_cnt = 0;
  logic          prev_inv3 = 1'b0;

  tlb_update_arbiter #(.N_SRC(2), .TLB_BITS(128), .TLB_ORDER(2)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done)
  );

  always #5 aclk = ~aclk;

  function automatic logic [127:0] inv(input int i);
    logic [127:0] v;
    v = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
    v[1:0] = 2'(i);
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Monitor: compares every accepted beat against the scoreboard queue.
  initial begin
    forever begin
      @(negedge aclk);
      if (flush_done === 1'b1) begin
        done_cnt++;
        chk("done_after_last_beat", {127'd0, prev_inv3}, 128'd1);
      end
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: actual=%h expected=none", m_tdata);
        end else begin
          chk("beat_data", m_tdata, exp_q.pop_front());
        end
        prev_inv3 = (m_tdata === inv(3));
      end else begin
        prev_inv3 = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int n1;
    int d0;
    logic seen;

    // Reset state, with a source asserting valid during reset
    s_tvalid = 2'b01;
    repeat (3) tick();
    @(negedge aclk);
    chk("rst_m_tvalid", {127'd0, m_tvalid}, 128'd0);
    chk("rst_s_tready", {126'd0, s_tready}, 128'd0);
    chk("rst_busy", {127'd0, flush_busy}, 128'd0);
    chk("rst_done", {127'd0, flush_done}, 128'd0);
    chk("rst_tdata", m_tdata, 128'd0);
    tick();
    aresetn = 1'b1;
    s_tvalid = 2'b00;
    m_tready = 1'b1;

    // Single source, one-cycle latency
    s_tdata[127:0] = 128'hAB;
    s_tvalid = 2'b01;
    exp_q.push_back(128'hAB);
    @(negedge aclk);
    chk("single_tready", {126'd0, s_tready}, 128'd1);
    chk("single_tvalid_pre", {127'd0, m_tvalid}, 128'd0);
    tick();
    s_tvalid = 2'b00;
    @(negedge aclk);
    chk("single_tvalid", {127'd0, m_tvalid}, 128'd1);
    chk("single_tdata", m_tdata, 128'hAB);
    tick();

    // One src1 beat returns the pointer to 0
    s_tdata[255:128] = 128'hCD;
    s_tvalid = 2'b10;
    exp_q.push_back(128'hCD);
    @(negedge aclk);
    chk("src1_tready", {126'd0, s_tready}, 128'd2);
    tick();

    // Contention: alternate src0/src1, no idle cycles
    for (int j = 0; j < 6; j++) begin
      exp_q.push_back(128'h100 + 128'(j));
      exp_q.push_back(128'h200 + 128'(j));
    end
    n0 = 0;
    n1 = 0;
    s_tvalid = 2'b11;
    for (int k = 0; k < 12; k++) begin
      s_tdata[127:0]   = 128'h100 + 128'(n0);
      s_tdata[255:128] = 128'h200 + 128'(n1);
      @(negedge aclk);
      chk("rr_grant", {126'd0, s_tready}, (k % 2 == 0) ? 128'd1 : 128'd2);
      if (k > 0) chk("no_idle", {127'd0, m_tvalid}, 128'd1);
      if (k % 2 == 0) n0++; else n1++;
      tick();
    end
    s_tvalid = 2'b00;
    @(negedge aclk);
    chk("no_idle_last", {127'd0, m_tvalid}, 128'd1);
    tick();

    // Backpressure: beat held stable, no readies, reload on release
    m_tready = 1'b0;
    s_tvalid = 2'b11;
    s_tdata[127:0]   = 128'h300;
    s_tdata[255:128] = 128'h400;
    exp_q.push_back(128'h300);
    exp_q.push_back(128'h400);
    @(negedge aclk);
    chk("bp_ptr_at_0", {126'd0, s_tready}, 128'd1);
    tick();
    s_tvalid = 2'b10;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      chk("bp_tdata", m_tdata, 128'h300);
      chk("bp_tvalid", {127'd0, m_tvalid}, 128'd1);
      chk("bp_tready", {126'd0, s_tready}, 128'd0);
      tick();
    end
    m_tready = 1'b1;
    @(negedge aclk);
    chk("bp_release_tready", {126'd0, s_tready}, 128'd2);
    tick();
    s_tvalid = 2'b00;
    @(negedge aclk);
    chk("bp_next_tdata", m_tdata, 128'h400);
    tick();

    // Flush while src1 streams; flush_req coincides with a handshake
    s_tvalid = 2'b10;
    s_tdata[255:128] = 128'h500;
    exp_q.push_back(128'h500);
    @(negedge aclk);
    chk("fl_pre_tready", {126'd0, s_tready}, 128'd2);
    tick();
    s_tdata[255:128] = 128'h501;
    flush_req = 1'b1;
    exp_q.push_back(128'h501);
    @(negedge aclk);
    chk("fl_same_cycle_tready", {126'd0, s_tready}, 128'd2);
    tick();
    flush_req = 1'b0;
    s_tdata[255:128] = 128'h502;
    for (int i = 0; i < 4; i++) exp_q.push_back(inv(i));
    exp_q.push_back(128'h502);
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge aclk);
      if (flush_done === 1'b1) begin
        seen = 1'b1;
        chk("fl_resume_tready", {126'd0, s_tready}, 128'd2);
        chk("fl_busy_clear", {127'd0, flush_busy}, 128'd0);
      end else begin
        chk("fl_tready_blocked", {126'd0, s_tready}, 128'd0);
        if (c == 3) chk("fl_busy", {127'd0, flush_busy}, 128'd1);
      end
      tick();
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL flush_timeout: actual=no_flush_done expected=flush_done");
    end
    s_tvalid = 2'b00;
    @(negedge aclk);
    chk("fl_resumed_tdata", m_tdata, 128'h502);
    tick();

    // Flush under stalls with a second request mid-flush
    d0 = done_cnt;
    flush_req = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(inv(i));
    tick();
    flush_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
      m_tready = (c % 2 == 0);
      flush_req = (c == 5);
      tick();
    end
    flush_req = 1'b0;
    m_tready = 1'b1;
    repeat (3) tick();
    @(negedge aclk);
    chk("stall_one_done", 128'(done_cnt - d0), 128'd1);
    chk("stall_busy_idle", {127'd0, flush_busy}, 128'd0);
    chk("stall_queue_empty", 128'(exp_q.size()), 128'd0);
    tick();

    // Reset after two invalidate beats accepted
    d0 = done_cnt;
    flush_req = 1'b1;
    exp_q.push_back(inv(0));
    exp_q.push_back(inv(1));
    tick();
    flush_req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge aclk);
      if (m_tvalid === 1'b1 && m_tdata === inv(1)) seen = 1'b1;
      else tick();
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL rstmid_timeout: actual=no_beat1 expected=beat1");
    end
    aresetn = 1'b0;
    tick();
    @(negedge aclk);
    chk("rstmid_tvalid", {127'd0, m_tvalid}, 128'd0);
    chk("rstmid_busy", {127'd0, flush_busy}, 128'd0);
    tick();
    aresetn = 1'b1;
    repeat (8) tick();
    chk("rstmid_no_done", 128'(done_cnt - d0), 128'd0);
    chk("rstmid_queue_empty", 128'(exp_q.size()), 128'd0);

    // Normal traffic after the aborted flush
    s_tdata[127:0] = 128'h777;
    s_tvalid = 2'b01;
    exp_q.push_back(128'h777);
    @(negedge aclk);
    chk("post_rst_tready", {126'd0, s_tready}, 128'd1);
    tick();
    s_tvalid = 2'b00;
    @(negedge aclk);
    chk("post_rst_tdata", m_tdata, 128'h777);
    chk("tlast_zero", {127'd0, m_tlast}, 128'd0);
    tick();
    repeat (2) tick();
    chk("final_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
